// File: rtl/sw_debounce9.sv
// Two-flop synchroniser plus joint 9-bit settle FSM feeding the priority encoder.
// Optional accepted-change counter enabled by defining SW_DEBOUNCE_CNT_EN.
module sw_debounce9 #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sw_in,
   input  logic       en_in,
   output logic [7:0] binary_out,
   output logic       enable_out,
   output logic       changed,
   output logic [7:0] change_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t           state_q, state_d;
   logic [8:0]       sync1_q, sync1_d;
   logic [8:0]       sync2_q, sync2_d;
   logic [8:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       out_q, out_d;
   logic             changed_q, changed_d;

   always_comb begin
      sync1_d   = {en_in, sw_in};
      sync2_d   = sync1_q;
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      changed_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q != cand_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            // Any bounce on any bit restarts the settle window for the whole vector.
            if (sync2_q != cand_q) begin
               cand_d = sync2_q;
               cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d = IDLE;
               if (cand_q != out_q) begin
                  out_d     = cand_q;
                  changed_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         changed_q <= changed_d;
      end
   end

   assign binary_out = out_q[7:0];
   assign enable_out = out_q[8];
   assign changed    = changed_q;

`ifdef SW_DEBOUNCE_CNT_EN
   logic [7:0] change_count_q, change_count_d;

   always_comb begin
      change_count_d = change_count_q + {7'd0, changed_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) change_count_q <= '0;
      else        change_count_q <= change_count_d;
   end

   assign change_count = change_count_q;
`else
   assign change_count = 8'h00;
`endif

endmodule

// File: tb/tb_sw_debounce9.sv
// Scoreboard bench for sw_debounce9: expected output changes are queued with
// their due cycle when stimulus is driven and checked every cycle.
module tb_sw_debounce9;

   localparam int STABLE_CYCLES = 4;
   localparam int LAT           = STABLE_CYCLES + 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw_in = 8'hFF;
   logic       en_in = 1'b1;
   logic [7:0] binary_out;
   logic       enable_out;
   logic       changed;
   logic [7:0] change_count;

   sw_debounce9 #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sw_in        (sw_in),
      .en_in        (en_in),
      .binary_out   (binary_out),
      .enable_out   (enable_out),
      .changed      (changed),
      .change_count (change_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] val;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   logic       rst_seen;
   bit         mon_en      = 1'b0;
   logic [8:0] cur_exp     = '0;
   logic       exp_chg     = 1'b0;
   logic [7:0] cnt_exp     = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [8:0] v);
      exp_t e;
      e.val = v;
      e.due = cyc + LAT;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst_n;
   end

   always @(negedge clk) begin
      if (rst_seen === 1'b0) begin
         mon_en  = 1'b1;
         sb.delete();
         cur_exp = '0;
         exp_chg = 1'b0;
         cnt_exp = '0;
      end else if (mon_en) begin
         exp_chg = 1'b0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            cur_exp = sb[0].val;
            exp_chg = 1'b1;
            void'(sb.pop_front());
         end
      end
      if (mon_en) begin
         check("outputs", {23'd0, enable_out, binary_out}, {23'd0, cur_exp});
         check("changed", {31'd0, changed}, {31'd0, exp_chg});
`ifdef SW_DEBOUNCE_CNT_EN
         check("change_count", {24'd0, change_count}, {24'd0, cnt_exp});
         if (exp_chg) cnt_exp = cnt_exp + 8'd1;
`else
         check("change_count", {24'd0, change_count}, 32'd0);
`endif
      end
   end

   initial begin
      // Reset held 3 cycles with all switches high, then released.
      step(3);
      rst_n = 1'b1;
      push(9'h1FF);
      step(12);

      // Clean steps.
      sw_in = 8'h00; en_in = 1'b0;
      push(9'h000);
      step(12);
      sw_in = 8'h24;
      push(9'h024);
      step(12);

      // Bounce 01/00 every 2 cycles, resting at 01.
      for (int i = 0; i < 5; i++) begin
         sw_in = (i % 2 == 0) ? 8'h01 : 8'h00;
         if (i == 4) push(9'h001);
         step(2);
      end
      step(10);

      // Glitch that returns to the current output value.
      sw_in = 8'h80;
      push(9'h080);
      step(12);
      sw_in = 8'h00;
      step(2);
      sw_in = 8'h80;
      step(12);

      // Reset mid-settle discards the pending candidate.
      sw_in = 8'h00;
      push(9'h000);
      step(12);
      sw_in = 8'h0F;
      push(9'h00F);
      step(2);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      push(9'h00F);
      step(12);

      // 257 accepted changes from a fresh reset.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 257; i++) begin
         sw_in = (i % 2 == 0) ? 8'h01 : 8'h02;
         push((i % 2 == 0) ? 9'h001 : 9'h002);
         step(8);
      end
      step(4);
`ifdef SW_DEBOUNCE_CNT_EN
      check("final_count", {24'd0, change_count}, 32'h01);
`else
      check("final_count", {24'd0, change_count}, 32'h00);
`endif
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
